// File: rtl/hot_bit_seq.sv
// One-hot position sequencer: load, rotate or clear a single set bit across DEPTH lines.
// Every output is registered; out_idx tracks the set bit's binary position.
module hot_bit_seq #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned BITS        = $clog2(DEPTH),
   parameter int unsigned RESET_INDEX = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [BITS-1:0]  index,
   output logic [DEPTH-1:0] out,
   output logic [BITS-1:0]  out_idx,
   output logic             active,
   output logic             wrap,
   output logic             err
);

   localparam logic [1:0] MODE_LOAD   = 2'b01;
   localparam logic [1:0] MODE_ROTATE = 2'b10;
   localparam logic [1:0] MODE_CLEAR  = 2'b11;

   localparam logic [BITS-1:0]  LAST_IDX  = BITS'(DEPTH - 1);
   localparam logic [BITS-1:0]  RESET_IDX = BITS'(RESET_INDEX);
   localparam logic [DEPTH-1:0] BIT0      = DEPTH'(1);
   localparam logic [DEPTH-1:0] RESET_OUT = BIT0 << RESET_INDEX;

   typedef enum logic {
      ST_EMPTY  = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t state;

   // Sequencer state and registered outputs; wrap/err are single-cycle pulses.
   always_ff @(posedge clk) begin
      wrap <= 1'b0;
      err  <= 1'b0;
      if (rst) begin
         state   <= ST_ACTIVE;
         out     <= RESET_OUT;
         out_idx <= RESET_IDX;
         active  <= 1'b1;
      end else if (en) begin
         case (mode)
            MODE_LOAD: begin
               // Out-of-range index (non-power-of-two DEPTH only) leaves the position untouched.
               if (32'(index) < DEPTH) begin
                  state   <= ST_ACTIVE;
                  out     <= BIT0 << index;
                  out_idx <= index;
                  active  <= 1'b1;
               end else begin
                  err <= 1'b1;
               end
            end
            MODE_ROTATE: begin
               if (state == ST_EMPTY) begin
                  state   <= ST_ACTIVE;
                  out     <= BIT0;
                  out_idx <= '0;
                  active  <= 1'b1;
               end else if (out_idx == LAST_IDX) begin
                  out     <= BIT0;
                  out_idx <= '0;
                  wrap    <= 1'b1;
               end else begin
                  out     <= out << 1;
                  out_idx <= out_idx + BITS'(1);
               end
            end
            MODE_CLEAR: begin
               state   <= ST_EMPTY;
               out     <= '0;
               out_idx <= '0;
               active  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hot_bit_seq.sv
// Bench for hot_bit_seq: four instances (DEPTH 2/5/8/16) share a command stream;
// a reference model feeds per-instance expectation queues checked every cycle.
module tb_hot_bit_seq;

   typedef struct packed {
      logic [15:0] out;
      logic [3:0]  idx;
      logic        active;
      logic        wrap;
      logic        err;
   } exp_t;

   localparam int DEP [4] = '{2, 5, 8, 16};
   localparam int RI  [4] = '{1, 2, 0, 5};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] idx_in = 8'd0;

   logic [1:0]  out_d2;  logic [0:0] idx_d2;  logic act_d2, wrap_d2, err_d2;
   logic [4:0]  out_d5;  logic [2:0] idx_d5;  logic act_d5, wrap_d5, err_d5;
   logic [7:0]  out_d8;  logic [2:0] idx_d8;  logic act_d8, wrap_d8, err_d8;
   logic [15:0] out_d16; logic [3:0] idx_d16; logic act_d16, wrap_d16, err_d16;

   int n_tests = 0;
   int n_fail  = 0;

   exp_t ms [4];
   exp_t q  [4][$];

   always #5 clk = ~clk;

   hot_bit_seq #(.DEPTH(2), .RESET_INDEX(1)) u_d2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .index(idx_in[0:0]),
      .out(out_d2), .out_idx(idx_d2), .active(act_d2), .wrap(wrap_d2), .err(err_d2));
   hot_bit_seq #(.DEPTH(5), .RESET_INDEX(2)) u_d5 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .index(idx_in[2:0]),
      .out(out_d5), .out_idx(idx_d5), .active(act_d5), .wrap(wrap_d5), .err(err_d5));
   hot_bit_seq #(.DEPTH(8), .RESET_INDEX(0)) u_d8 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .index(idx_in[2:0]),
      .out(out_d8), .out_idx(idx_d8), .active(act_d8), .wrap(wrap_d8), .err(err_d8));
   hot_bit_seq #(.DEPTH(16), .RESET_INDEX(5)) u_d16 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .index(idx_in[3:0]),
      .out(out_d16), .out_idx(idx_d16), .active(act_d16), .wrap(wrap_d16), .err(err_d16));

   exp_t got [4];
   assign got[0] = {16'(out_d2),  4'(idx_d2),  act_d2,  wrap_d2,  err_d2};
   assign got[1] = {16'(out_d5),  4'(idx_d5),  act_d5,  wrap_d5,  err_d5};
   assign got[2] = {16'(out_d8),  4'(idx_d8),  act_d8,  wrap_d8,  err_d8};
   assign got[3] = {out_d16,      idx_d16,     act_d16, wrap_d16, err_d16};

   // Reference behaviour for one instance of width d.
   function automatic exp_t model(input int d, input int ri, input exp_t s,
                                  input logic r, input logic e, input logic [1:0] m,
                                  input logic [7:0] ix);
      exp_t n;
      int   ixm;
      n      = s;
      n.wrap = 1'b0;
      n.err  = 1'b0;
      ixm    = int'(ix) % (1 << $clog2(d));
      if (r) begin
         n.out = 16'd1 << ri; n.idx = 4'(ri); n.active = 1'b1;
      end else if (e) begin
         if (m == 2'b01) begin
            if (ixm < d) begin
               n.out = 16'd1 << ixm; n.idx = 4'(ixm); n.active = 1'b1;
            end else begin
               n.err = 1'b1;
            end
         end else if (m == 2'b10) begin
            if (!s.active) begin
               n.out = 16'd1; n.idx = 4'd0; n.active = 1'b1;
            end else if (int'(s.idx) == d - 1) begin
               n.out = 16'd1; n.idx = 4'd0; n.wrap = 1'b1;
            end else begin
               n.out = 16'd1 << (int'(s.idx) + 1); n.idx = s.idx + 4'd1;
            end
         end else if (m == 2'b11) begin
            n.out = 16'd0; n.idx = 4'd0; n.active = 1'b0;
         end
      end
      return n;
   endfunction

   // Scoreboard: pop one expectation per instance after each edge, plus structural invariants.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 4; i++) begin
         if (q[i].size() > 0) begin
            exp_t e;
            e = q[i].pop_front();
            n_tests++;
            if (got[i] !== e) begin
               n_fail++;
               $display("FAIL sb_depth%0d got=%h exp=%h", DEP[i], got[i], e);
            end
            n_tests++;
            if (!($onehot0(got[i].out) && (got[i].active == $onehot(got[i].out)) &&
                  (got[i].active ? (got[i].out == (16'd1 << got[i].idx)) : (got[i].idx == 4'd0)) &&
                  !(got[i].wrap && got[i].err))) begin
               n_fail++;
               $display("FAIL invariant_depth%0d got=%h", DEP[i], got[i]);
            end
         end
      end
   end

   task automatic step(input logic r, input logic e, input logic [1:0] m, input logic [7:0] ix);
      @(negedge clk);
      rst = r; en = e; mode = m; idx_in = ix;
      for (int i = 0; i < 4; i++) begin
         ms[i] = model(DEP[i], RI[i], ms[i], r, e, m, ix);
         q[i].push_back(ms[i]);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 2'b00, 8'd0);
      n_tests++;
      if ({out_d8, idx_d8, act_d8, wrap_d8, err_d8} !== {8'h01, 3'd0, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_d8 got=%h exp=%h", {out_d8, idx_d8, act_d8, wrap_d8, err_d8},
                  {8'h01, 3'd0, 1'b1, 1'b0, 1'b0});
      end
      n_tests++;
      if ({out_d5, idx_d5, act_d5} !== {5'b00100, 3'd2, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_d5 got=%h exp=%h", {out_d5, idx_d5, act_d5}, {5'b00100, 3'd2, 1'b1});
      end
   endtask

   task automatic test_rotate_wrap();
      logic [7:0] eo [4] = '{8'h40, 8'h80, 8'h01, 8'h02};
      logic [2:0] ei [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, (k == 0) ? 2'b01 : 2'b10, 8'd6);
         n_tests++;
         if ({out_d8, idx_d8, wrap_d8} !== {eo[k], ei[k], k == 2}) begin
            n_fail++;
            $display("FAIL rotate_d8_%0d got=%h exp=%h", k, {out_d8, idx_d8, wrap_d8},
                     {eo[k], ei[k], k == 2});
         end
      end
   endtask

   task automatic test_bad_load();
      step(1'b0, 1'b1, 2'b01, 8'd3);
      step(1'b0, 1'b1, 2'b01, 8'd6);
      n_tests++;
      if ({out_d5, idx_d5, err_d5} !== {5'b01000, 3'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL badload_d5 got=%h exp=%h", {out_d5, idx_d5, err_d5}, {5'b01000, 3'd3, 1'b1});
      end
      step(1'b0, 1'b1, 2'b10, 8'd0);
      n_tests++;
      if ({out_d5, err_d5, wrap_d5} !== {5'b10000, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL rot1_d5 got=%h exp=%h", {out_d5, err_d5, wrap_d5}, {5'b10000, 1'b0, 1'b0});
      end
      step(1'b0, 1'b1, 2'b10, 8'd0);
      n_tests++;
      if ({out_d5, idx_d5, wrap_d5} !== {5'b00001, 3'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL rot2_d5 got=%h exp=%h", {out_d5, idx_d5, wrap_d5}, {5'b00001, 3'd0, 1'b1});
      end
   endtask

   task automatic test_clear();
      step(1'b0, 1'b1, 2'b11, 8'd0);
      n_tests++;
      if ({out_d8, idx_d8, act_d8} !== {8'h00, 3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL clear_d8 got=%h exp=%h", {out_d8, idx_d8, act_d8}, {8'h00, 3'd0, 1'b0});
      end
      step(1'b0, 1'b1, 2'b10, 8'd0);
      n_tests++;
      if ({out_d8, act_d8, wrap_d8} !== {8'h01, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL clear_rot_d8 got=%h exp=%h", {out_d8, act_d8, wrap_d8}, {8'h01, 1'b1, 1'b0});
      end
   endtask

   task automatic test_hold_reset();
      step(1'b0, 1'b1, 2'b01, 8'd7);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, 2'b10, 8'd0);
         n_tests++;
         if ({out_d8, idx_d8, wrap_d8} !== {8'h80, 3'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_d8_%0d got=%h exp=%h", k, {out_d8, idx_d8, wrap_d8}, {8'h80, 3'd7, 1'b0});
         end
      end
      step(1'b1, 1'b1, 2'b10, 8'd0);
      n_tests++;
      if ({out_d8, idx_d8, wrap_d8, err_d8} !== {8'h01, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_rot_d8 got=%h exp=%h", {out_d8, idx_d8, wrap_d8, err_d8}, {8'h01, 3'd0, 1'b0, 1'b0});
      end
      step(1'b0, 1'b0, 2'b00, 8'd0);
      n_tests++;
      if ({wrap_d8, err_d8, wrap_d5, err_d5} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_residual got=%b exp=0000", {wrap_d8, err_d8, wrap_d5, err_d5});
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 800; k++) begin
         step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end
      n_tests++;
      if (q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain got=%0d exp=0", q[0].size() + q[1].size() + q[2].size() + q[3].size());
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) ms[i] = '0;
      test_reset();
      test_rotate_wrap();
      test_bad_load();
      test_clear();
      test_hold_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
